// File: rtl/multdiv_unit_if.sv
// rtl/multdiv_unit_if.sv - request/result bundle between a requester and multdiv_unit
interface multdiv_unit_if;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - 32-bit signed multi-cycle multiply/divide, one bit per cycle
module multdiv_unit (
   input  logic          clock,
   input  logic          reset,
   multdiv_unit_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [5:0]  r_count;
   logic [31:0] r_a_mag;
   logic [31:0] r_b_mag;
   logic        r_neg;
   logic        r_div_zero;
   logic        r_div_ovf;
   // multiply: {partial product high, remaining multiplier}; divide: low half shifts dividend out / quotient in
   logic [63:0] r_acc;
   logic [31:0] r_rem;
   logic [31:0] r_result;
   logic        r_exception;
   logic        r_rdy;
   logic        r_busy;

   logic        w_start;
   logic        w_last;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_add;
   logic [63:0] w_mul_next;
   logic [63:0] w_prod;
   logic        w_mul_exc;
   logic [32:0] w_shift;
   logic        w_fits;
   logic [31:0] w_diff;
   logic [31:0] w_quo_next;
   logic [31:0] w_quo_signed;

   assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
   assign w_last  = (r_count == 6'd31);
   assign w_a_mag = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
   assign w_b_mag = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;

   // shift-add step: conditionally add multiplicand to the high half, then shift the pair right
   assign w_add      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a_mag} : 33'd0);
   assign w_mul_next = {w_add, r_acc[31:1]};
   assign w_prod     = r_neg ? (64'd0 - w_mul_next) : w_mul_next;
   assign w_mul_exc  = (|w_prod[63:31]) & ~(&w_prod[63:31]);

   // restoring step: the 33-bit partial remainder is the stored remainder shifted left with the next dividend bit
   assign w_shift      = {r_rem, r_acc[31]};
   assign w_fits       = (w_shift >= {1'b0, r_b_mag});
   // when w_fits the true difference is below the divisor, so 32 bits hold it exactly
   assign w_diff       = w_shift[31:0] - r_b_mag;
   assign w_quo_next   = {r_acc[30:0], w_fits};
   assign w_quo_signed = r_neg ? (32'd0 - w_quo_next) : w_quo_next;

   assign bus.data_result    = r_result;
   assign bus.data_exception = r_exception;
   assign bus.data_resultRDY = r_rdy;
   assign bus.busy           = r_busy;

   // state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // next state: 32 iterations then DONE; a new request restarts from any state, MULT winning ties
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: w_next_state = S_IDLE;
         S_MULT: if (w_last) w_next_state = S_DONE;
         S_DIV:  if (w_last) w_next_state = S_DONE;
         S_DONE: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
      if (w_start) w_next_state = bus.ctrl_MULT ? S_MULT : S_DIV;
   end

   // datapath: latch magnitudes on start, iterate, and register the signed result on the last iteration
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count     <= 6'd0;
         r_a_mag     <= 32'd0;
         r_b_mag     <= 32'd0;
         r_neg       <= 1'b0;
         r_div_zero  <= 1'b0;
         r_div_ovf   <= 1'b0;
         r_acc       <= 64'd0;
         r_rem       <= 32'd0;
         r_result    <= 32'd0;
         r_exception <= 1'b0;
         r_rdy       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rdy  <= (w_next_state == S_DONE);
         r_busy <= (w_next_state == S_MULT) || (w_next_state == S_DIV);
         if (w_start) begin
            r_count    <= 6'd0;
            r_a_mag    <= w_a_mag;
            r_b_mag    <= w_b_mag;
            r_neg      <= bus.data_operandA[31] ^ bus.data_operandB[31];
            r_div_zero <= (bus.data_operandB == 32'd0);
            r_div_ovf  <= (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == 32'hFFFF_FFFF);
            r_acc      <= {32'd0, bus.ctrl_MULT ? w_b_mag : w_a_mag};
            r_rem      <= 32'd0;
         end else if (r_state == S_MULT) begin
            r_count <= r_count + 6'd1;
            r_acc   <= w_mul_next;
            if (w_last) begin
               r_result    <= w_prod[31:0];
               r_exception <= w_mul_exc;
            end
         end else if (r_state == S_DIV) begin
            r_count <= r_count + 6'd1;
            r_acc   <= {r_acc[63:32], w_quo_next};
            r_rem   <= w_fits ? w_diff : w_shift[31:0];
            if (w_last) begin
               if (r_div_zero) begin
                  r_result    <= 32'd0;
                  r_exception <= 1'b1;
               end else if (r_div_ovf) begin
                  r_result    <= 32'h8000_0000;
                  r_exception <= 1'b1;
               end else begin
                  r_result    <= w_quo_signed;
                  r_exception <= 1'b0;
               end
            end
         end
      end
   end
endmodule
